// File: rtl/ros2_config.sv
// Project-wide configuration shared by the ROS2/Ethernet blocks.
package ros2_config;
  localparam int UDP_TXBUF_AWIDTH = 6;
endpackage

// File: rtl/udp_tx_packer_pkg.sv
// Shared UDP TX buffer definitions: word map, FSM encoding, header record.
package udp_tx_packer_pkg;
  import ros2_config::*;

  typedef logic [UDP_TXBUF_AWIDTH-1:0] txbuf_addr_t;

  localparam txbuf_addr_t HDR_IP       = txbuf_addr_t'(0);
  localparam txbuf_addr_t HDR_PORT     = txbuf_addr_t'(1);
  localparam txbuf_addr_t HDR_LEN      = txbuf_addr_t'(2);
  localparam txbuf_addr_t PAYLOAD_BASE = txbuf_addr_t'(3);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_RELEASE,
    ST_WAIT_GRANT
  } state_t;

  typedef struct packed {
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
  } udp_hdr_t;
endpackage

// File: rtl/udp_txbuf_ram.sv
// Simple dual-port payload RAM: one write port, one registered read port.
module udp_txbuf_ram #(
  parameter int AW = 6,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/udp_tx_packer.sv
// Packs a byte stream into the UDP TX buffer (3 header words + payload words)
// and hands the buffer to ros2_ether, waiting for it to come back.
module udp_tx_packer
  import ros2_config::*;
  import udp_tx_packer_pkg::*;
#(
  parameter int MAX_PAYLOAD = 244
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [31:0]                 hdr_dst_ip,
  input  logic [15:0]                 hdr_src_port,
  input  logic [15:0]                 hdr_dst_port,
  input  logic [7:0]                  s_data,
  input  logic                        s_valid,
  input  logic                        s_last,
  output logic                        s_ready,
  output logic                        udp_txbuf_rel,
  input  logic                        udp_txbuf_grant,
  input  logic [UDP_TXBUF_AWIDTH-1:0] udp_txbuf_addr,
  input  logic                        udp_txbuf_ce,
  output logic [31:0]                 udp_txbuf_rdata,
  output logic                        busy,
  output logic [15:0]                 frames_sent,
  output logic [15:0]                 frames_dropped
);
  state_t          state, state_nxt;
  logic            wg_first;
  logic [15:0]     byte_cnt;
  logic [15:0]     cur_idx;
  logic [1:0]      lane_sel;
  logic [3:0][7:0] lane_acc;
  udp_hdr_t        hdr;
  logic            accept, abort;
  logic            ram_we, ram_re;
  txbuf_addr_t     ram_waddr;
  logic [3:0][7:0] ram_wdata;
  logic [31:0]     ram_rdata, hdr_q;
  logic            sel_ram;

  // Accept is derived from state, not s_ready, so abort stays loop-free.
  assign accept   = s_valid && (state == ST_IDLE || state == ST_FILL);
  assign cur_idx  = (state == ST_IDLE) ? 16'd0 : byte_cnt;
  assign lane_sel = cur_idx[1:0];
  assign abort    = s_valid && (state == ST_FILL) && (byte_cnt == 16'(MAX_PAYLOAD));
  assign ram_we   = accept && !abort && (lane_sel == 2'd3 || s_last);
  assign ram_waddr = PAYLOAD_BASE + txbuf_addr_t'(cur_idx[15:2]);
  assign busy     = (state != ST_IDLE);

  always_comb begin
    ram_wdata = '0;
    for (int l = 0; l < 4; l++) begin
      if (2'(l) < lane_sel)       ram_wdata[l] = lane_acc[l];
      else if (2'(l) == lane_sel) ram_wdata[l] = s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wg_first <= 1'b0;
    end else begin
      state    <= state_nxt;
      wg_first <= (state == ST_RELEASE);
    end
  end

  always_comb begin
    state_nxt     = state;
    s_ready       = 1'b0;
    udp_txbuf_rel = 1'b0;
    case (state)
      ST_IDLE: begin
        s_ready = 1'b1;
        if (s_valid) state_nxt = s_last ? ST_RELEASE : ST_FILL;
      end
      ST_FILL: begin
        s_ready = 1'b1;
        if (abort)        state_nxt = ST_IDLE;
        else if (s_valid) state_nxt = s_last ? ST_RELEASE : ST_FILL;
      end
      ST_RELEASE: begin
        udp_txbuf_rel = 1'b1;
        state_nxt     = ST_WAIT_GRANT;
      end
      ST_WAIT_GRANT: begin
        // The grant level may still be high from the previous hand-off.
        if (!wg_first && udp_txbuf_grant) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_cnt       <= '0;
      hdr            <= '0;
      lane_acc       <= '0;
      frames_sent    <= '0;
      frames_dropped <= '0;
    end else begin
      if (accept) begin
        if (state == ST_IDLE) hdr <= '{hdr_dst_ip, hdr_src_port, hdr_dst_port};
        lane_acc[lane_sel] <= s_data;
        byte_cnt           <= abort ? 16'd0 : cur_idx + 16'd1;
      end
      if (udp_txbuf_rel) frames_sent    <= frames_sent + 16'd1;
      if (abort)         frames_dropped <= frames_dropped + 16'd1;
    end
  end

  // Header words come from a local register, payload words from the RAM's
  // own output register; sel_ram picks which one is current.
  assign ram_re = udp_txbuf_ce && (udp_txbuf_addr >= PAYLOAD_BASE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hdr_q   <= '0;
      sel_ram <= 1'b0;
    end else if (udp_txbuf_ce) begin
      sel_ram <= (udp_txbuf_addr >= PAYLOAD_BASE);
      if (udp_txbuf_addr == HDR_IP)        hdr_q <= hdr.dst_ip;
      else if (udp_txbuf_addr == HDR_PORT) hdr_q <= {hdr.src_port, hdr.dst_port};
      else if (udp_txbuf_addr == HDR_LEN)  hdr_q <= {16'h0, byte_cnt};
    end
  end

  assign udp_txbuf_rdata = sel_ram ? ram_rdata : hdr_q;

  udp_txbuf_ram #(.AW(UDP_TXBUF_AWIDTH), .DW(32)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (udp_txbuf_addr),
    .rdata (ram_rdata)
  );
endmodule

// File: tb/tb_udp_tx_packer.sv
// Directed bench for udp_tx_packer with a frame-level reference model.
module tb_udp_tx_packer;
  localparam int MAXP = 244;
  typedef logic [7:0] bq_t[$];

  logic        clk = 0, rst_n = 0;
  logic [31:0] hdr_dst_ip = 0;
  logic [15:0] hdr_src_port = 0, hdr_dst_port = 0;
  logic [7:0]  s_data = 0;
  logic        s_valid = 0, s_last = 0, s_ready;
  logic        udp_txbuf_rel, udp_txbuf_grant = 0, udp_txbuf_ce = 0, busy;
  logic [5:0]  udp_txbuf_addr = 0;
  logic [31:0] udp_txbuf_rdata;
  logic [15:0] frames_sent, frames_dropped;

  int tests = 0, fails = 0, rel_cnt = 0;
  bit started = 0;

  udp_tx_packer #(.MAX_PAYLOAD(MAXP)) dut (
    .clk(clk), .rst_n(rst_n), .hdr_dst_ip(hdr_dst_ip), .hdr_src_port(hdr_src_port),
    .hdr_dst_port(hdr_dst_port), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .udp_txbuf_rel(udp_txbuf_rel), .udp_txbuf_grant(udp_txbuf_grant),
    .udp_txbuf_addr(udp_txbuf_addr), .udp_txbuf_ce(udp_txbuf_ce),
    .udp_txbuf_rdata(udp_txbuf_rdata), .busy(busy), .frames_sent(frames_sent),
    .frames_dropped(frames_dropped));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  // ph: 0 = taking bytes, 1 = handing buffer over, 2 = waiting for it back
  int          ph = 0, cnt = 0;
  bit          wfirst = 0, rd_chk = 0;
  logic [31:0] m_ip = 0, m_ports = 0, m_len = 0, m_acc = 0, exp_rd = 0;
  logic [15:0] m_sent = 0, m_drop = 0;
  logic [31:0] m_mem [64];
  bit          m_memv [64];

  always @(posedge clk) begin
    if (!rst_n) begin
      ph = 0; cnt = 0; m_sent = 0; m_drop = 0;
      m_ip = 0; m_ports = 0; m_len = 0; exp_rd = 0; rd_chk = 1;
    end else begin
      if (udp_txbuf_ce) begin
        rd_chk = (ph == 2) && (udp_txbuf_addr < 3 || m_memv[udp_txbuf_addr]);
        case (udp_txbuf_addr)
          0: exp_rd = m_ip;
          1: exp_rd = m_ports;
          2: exp_rd = m_len;
          default: exp_rd = m_mem[udp_txbuf_addr];
        endcase
      end
      case (ph)
        0: if (s_valid) begin
          if (cnt == MAXP) begin
            m_drop++; cnt = 0;
          end else begin
            if (cnt == 0) begin
              m_ip = hdr_dst_ip; m_ports = {hdr_src_port, hdr_dst_port}; m_acc = 0;
            end
            if (cnt % 4 == 0) m_acc = 0;
            m_acc[8*(cnt%4) +: 8] = s_data;
            if (cnt % 4 == 3 || s_last) begin
              m_mem[3 + cnt/4] = m_acc; m_memv[3 + cnt/4] = 1;
            end
            cnt++;
            m_len = cnt;
            if (s_last) ph = 1;
          end
        end
        1: begin m_sent++; ph = 2; wfirst = 1; end
        default: if (wfirst) wfirst = 0;
                 else if (udp_txbuf_grant) begin ph = 0; cnt = 0; end
      endcase
    end
  end

  always @(negedge clk) begin
    if (udp_txbuf_rel) rel_cnt++;
    if (started) begin
      chk("s_ready", 32'(s_ready), 32'(ph == 0));
      chk("rel", 32'(udp_txbuf_rel), 32'(ph == 1));
      chk("busy", 32'(busy), 32'(!(ph == 0 && cnt == 0)));
      chk("frames_sent", 32'(frames_sent), 32'(m_sent));
      chk("frames_dropped", 32'(frames_dropped), 32'(m_drop));
      if (rd_chk) chk("rdata", udp_txbuf_rdata, exp_rd);
    end
  end

  // ---------------- drivers (all start/end at posedge+1) ----------------
  task automatic send(input bq_t d, input logic [31:0] ip, input logic [15:0] sp, dp,
                      input bit with_last);
    hdr_dst_ip = ip; hdr_src_port = sp; hdr_dst_port = dp;
    foreach (d[i]) begin
      int to = 0;
      s_valid = 1; s_data = d[i]; s_last = with_last && (i == d.size() - 1);
      while (!s_ready && to < 500) begin @(posedge clk); #1; to++; end
      if (to >= 500) chk("send_timeout", 32'(s_ready), 32'd1);
      @(posedge clk); #1;
    end
    s_valid = 0; s_last = 0;
  endtask

  task automatic rd(input int a, output logic [31:0] d);
    udp_txbuf_ce = 1; udp_txbuf_addr = 6'(a);
    @(posedge clk); #1;
    udp_txbuf_ce = 0; d = udp_txbuf_rdata;
  endtask

  task automatic give_back();
    int to = 0;
    udp_txbuf_grant = 1;
    @(posedge clk); #1;
    while (!s_ready && to < 50) begin @(posedge clk); #1; to++; end
    if (to >= 50) chk("grant_timeout", 32'(s_ready), 32'd1);
    udp_txbuf_grant = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    bq_t f;
    logic [31:0] w;
    int rc;
    string msg;
    logic [31:0] exp_a [7];

    idle(1); started = 1; idle(2);
    rst_n = 1;
    chk("rst_ready", 32'(s_ready), 1);
    chk("rst_rel", 32'(udp_txbuf_rel), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sent", 32'(frames_sent), 0);
    chk("rst_dropped", 32'(frames_dropped), 0);
    chk("rst_rdata", udp_txbuf_rdata, 0);

    // Text frame; byte 13 is '\n' (0x0a) and lands in lane 1 of word 6.
    msg = "UDP Send Test\n";
    f = {};
    for (int i = 0; i < msg.len(); i++) f.push_back(msg[i]);
    send(f, {8'd10, 8'd1, 8'd168, 8'd192}, 16'd1111, 16'd1234, 1);
    idle(2);
    exp_a = '{32'h0a01a8c0, 32'h045704d2, 32'h0000000e, 32'h20504455,
              32'h646e6553, 32'h73655420, 32'h00000a74};
    for (int a = 0; a < 7; a++) begin
      rd(a, w);
      chk($sformatf("text_word%0d", a), w, exp_a[a]);
    end
    chk("text_rel_cnt", 32'(rel_cnt), 1);
    give_back();

    // Single byte frame: rel must be up right after the byte is taken.
    send('{8'hAB}, 32'h01020304, 16'd5, 16'd6, 1);
    chk("one_byte_rel_now", 32'(udp_txbuf_rel), 1);
    idle(1);
    rd(2, w); chk("one_byte_len", w, 32'h00000001);
    rd(3, w); chk("one_byte_word3", w, 32'h000000AB);
    give_back();

    // Oversize frame is dropped, following short frame goes through.
    rc = rel_cnt;
    f = {};
    for (int i = 0; i < MAXP + 1; i++) f.push_back(8'(i * 7));
    send(f, 32'hdeadbeef, 16'd1, 16'd2, 1);
    idle(1);
    chk("drop_no_rel", 32'(rel_cnt), 32'(rc));
    chk("drop_count", 32'(frames_dropped), 1);
    send('{8'h01, 8'h02, 8'h03, 8'h04}, 32'h0a000001, 16'd7, 16'd8, 1);
    idle(2);
    chk("after_drop_rel", 32'(rel_cnt), 32'(rc + 1));
    rd(2, w); chk("after_drop_len", w, 32'h00000004);
    rd(3, w); chk("after_drop_word3", w, 32'h04030201);
    rd(4, w); chk("after_drop_word4", w, 32'(8'(4 * 7)) | (32'(8'(5 * 7)) << 8) |
                                          (32'(8'(6 * 7)) << 16) | (32'(8'(7 * 7)) << 24));

    // Buffer kept by ros2_ether for 100 cycles.
    idle(100);
    chk("held_not_ready", 32'(s_ready), 0);
    udp_txbuf_grant = 1;
    idle(1);
    chk("ready_after_grant", 32'(s_ready), 1);
    udp_txbuf_grant = 0;
    send('{8'h55, 8'h66}, 32'h11223344, 16'h0102, 16'h0304, 1);
    idle(2);
    rd(3, w); chk("post_hold_word3", w, 32'h00006655);
    rd(1, w); chk("post_hold_ports", w, 32'h01020304);
    give_back();

    // Reset in the middle of a frame.
    rc = rel_cnt;
    f = {};
    for (int i = 0; i < 7; i++) f.push_back(8'(8'hA0 + i));
    send(f, 32'h99999999, 16'd9, 16'd9, 0);
    rst_n = 0; idle(2); rst_n = 1;
    chk("midrst_no_rel", 32'(rel_cnt), 32'(rc));
    chk("midrst_sent", 32'(frames_sent), 0);
    chk("midrst_busy", 32'(busy), 0);
    send('{8'h11, 8'h22, 8'h33}, 32'h0b0c0d0e, 16'd20, 16'd30, 1);
    idle(2);
    chk("midrst_rel", 32'(rel_cnt), 32'(rc + 1));
    rd(2, w); chk("midrst_len", w, 32'h00000003);
    rd(3, w); chk("midrst_word3", w, 32'h00332211);
    rd(0, w); chk("midrst_ip", w, 32'h0b0c0d0e);
    give_back();

    // Largest legal frame fills the last buffer word.
    f = {};
    for (int i = 0; i < MAXP; i++) f.push_back(8'(i));
    send(f, 32'h0, 16'hffff, 16'h0, 1);
    idle(2);
    rd(2, w);  chk("max_len", w, 32'h000000F4);
    rd(63, w); chk("max_word63", w, 32'hf3f2f1f0);
    rd(3, w);  chk("max_word3", w, 32'h03020100);
    chk("max_sent", 32'(frames_sent), 2);
    give_back();
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
